// File: rtl/cpu_mc.sv
// cpu_mc: posedge-only multicycle core for the 32-bit, 16-register ISA, with a valid/ready memory port.
// Optional cycle/instret counters are built only when CPU_MC_PERF_EN is defined.
module cpu_mc #(
    parameter int unsigned       ADDR_W   = 30,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int unsigned       LR_SEL   = 15
) (
    input  logic              clk,
    input  logic              rst,
    // mem_req/mem_we/mem_addr/mem_wdata are registered and held stable until the
    // cycle mem_ready is high; the request completes (and mem_rdata is taken) at that posedge.
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_ready,
    output logic              trap,
    output logic              retire,
    output logic [31:0]       pc_out,
    output logic [31:0]       cycle_cnt,
    output logic [31:0]       instret_cnt,
    output logic [2:0]        dbg_state
);

    typedef enum logic [2:0] {
        S_RESET = 3'd0,
        S_FETCH = 3'd1,
        S_EXEC  = 3'd2,
        S_LOAD  = 3'd3,
        S_STORE = 3'd4,
        S_TRAP  = 3'd5
    } state_e;

    state_e            state_q;
    logic [ADDR_W-1:0] pc_q;
    logic [31:0]       ir_q;
    logic              trap_q, retire_q, mem_req_q, mem_we_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [31:0]       mem_wdata_q;
    logic [31:0]       regs_q [16];

    logic [1:0]        form, op;
    logic [3:0]        rd, aluop, ra, rb;
    logic [31:0]       imm16_sx, rd_val, ra_val, rb_val, alu_b, alu_res, link_val;
    logic [ADDR_W-1:0] imm22_sx, ea, br_target;
    logic              is_alu, is_load, is_store, is_branch, is_undef, taken, accept, retire_d;
    logic              rf_we;
    logic [3:0]        rf_waddr;
    logic [31:0]       rf_wdata;

    assign form     = ir_q[31:30];
    assign op       = ir_q[29:28];
    assign rd       = ir_q[27:24];
    assign aluop    = ir_q[23:20];
    assign ra       = ir_q[19:16];
    assign rb       = ir_q[15:12];
    assign imm16_sx = {{16{ir_q[15]}}, ir_q[15:0]};
    assign imm22_sx = ADDR_W'($signed(ir_q[21:0]));

    assign is_branch = (form == 2'b10);
    assign is_undef  = (form == 2'b11);
    assign is_load   = !form[1] && (op == 2'b01);
    assign is_store  = !form[1] && (op == 2'b10);
    assign is_alu    = !form[1] && ((op == 2'b00) || (op == 2'b11));

    // Three read ports; r0 reads as zero regardless of array contents.
    assign rd_val = (rd == 4'd0) ? 32'd0 : regs_q[rd];
    assign ra_val = (ra == 4'd0) ? 32'd0 : regs_q[ra];
    assign rb_val = (rb == 4'd0) ? 32'd0 : regs_q[rb];
    assign alu_b  = form[0] ? rb_val : imm16_sx;

    always_comb begin
        alu_res = ra_val + alu_b;
        case (aluop)
            4'd1:    alu_res = ra_val - alu_b;
            4'd2:    alu_res = ra_val & alu_b;
            4'd3:    alu_res = ra_val | alu_b;
            4'd4:    alu_res = ra_val ^ alu_b;
            4'd5:    alu_res = ra_val << alu_b[4:0];
            4'd6:    alu_res = ra_val >> alu_b[4:0];
            4'd7:    alu_res = $signed(ra_val) >>> alu_b[4:0];
            4'd8:    alu_res = {31'd0, $signed(ra_val) < $signed(alu_b)};
            4'd9:    alu_res = {31'd0, ra_val < alu_b};
            4'd10:   alu_res = alu_b;
            default: alu_res = ra_val + alu_b;
        endcase
    end

    assign ea        = alu_res[ADDR_W+1:2];
    assign taken     = !ir_q[23] || (ir_q[22] ? (rd_val != 32'd0) : (rd_val == 32'd0));
    // pc_q already points past the branch, so it is both the link value and the relative base.
    assign br_target = ir_q[29] ? ra_val[ADDR_W+1:2] : (pc_q + imm22_sx);
    assign link_val  = 32'({pc_q, 2'b00});
    assign accept    = mem_req_q && mem_ready;
    assign retire_d  = ((state_q == S_EXEC) && !is_undef && !is_load && !is_store) ||
                       (((state_q == S_LOAD) || (state_q == S_STORE)) && accept);

    always_comb begin
        rf_we    = 1'b0;
        rf_waddr = rd;
        rf_wdata = alu_res;
        if (!rst) begin
            if ((state_q == S_EXEC) && is_alu) begin
                rf_we = 1'b1;
            end else if ((state_q == S_EXEC) && is_branch && ir_q[28]) begin
                rf_we    = 1'b1;
                rf_waddr = 4'(LR_SEL);
                rf_wdata = link_val;
            end else if ((state_q == S_LOAD) && accept) begin
                rf_we    = 1'b1;
                rf_wdata = mem_rdata;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rf_we && (rf_waddr != 4'd0)) begin
            regs_q[rf_waddr] <= rf_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_RESET;
            pc_q        <= RESET_PC;
            ir_q        <= '0;
            trap_q      <= 1'b0;
            retire_q    <= 1'b0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            retire_q <= retire_d;
            case (state_q)
                S_RESET: begin
                    state_q    <= S_FETCH;
                    mem_req_q  <= 1'b1;
                    mem_we_q   <= 1'b0;
                    mem_addr_q <= pc_q;
                end
                S_FETCH: begin
                    if (accept) begin
                        ir_q      <= mem_rdata;
                        pc_q      <= pc_q + ADDR_W'(1);
                        mem_req_q <= 1'b0;
                        state_q   <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    if (is_undef) begin
                        trap_q  <= 1'b1;
                        state_q <= S_TRAP;
                    end else if (is_load || is_store) begin
                        state_q     <= is_load ? S_LOAD : S_STORE;
                        mem_req_q   <= 1'b1;
                        mem_we_q    <= is_store;
                        mem_addr_q  <= ea;
                        mem_wdata_q <= is_store ? rd_val : 32'd0;
                    end else begin
                        state_q   <= S_FETCH;
                        mem_req_q <= 1'b1;
                        mem_we_q  <= 1'b0;
                        if (is_branch && taken) begin
                            pc_q       <= br_target;
                            mem_addr_q <= br_target;
                        end else begin
                            mem_addr_q <= pc_q;
                        end
                    end
                end
                S_LOAD, S_STORE: begin
                    if (accept) begin
                        state_q     <= S_FETCH;
                        mem_we_q    <= 1'b0;
                        mem_addr_q  <= pc_q;
                        mem_wdata_q <= '0;
                    end
                end
                S_TRAP: begin
                    mem_req_q <= 1'b0;
                end
                default: begin
                    state_q   <= S_RESET;
                    mem_req_q <= 1'b0;
                end
            endcase
        end
    end

    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign trap      = trap_q;
    assign retire    = retire_q;
    assign pc_out    = link_val;
    assign dbg_state = state_q;

`ifdef CPU_MC_PERF_EN
    logic [31:0] cycle_cnt_q, instret_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            cycle_cnt_q   <= '0;
            instret_cnt_q <= '0;
        end else begin
            if ((state_q != S_RESET) && (state_q != S_TRAP)) begin
                cycle_cnt_q <= cycle_cnt_q + 32'd1;
            end
            if (retire_d) begin
                instret_cnt_q <= instret_cnt_q + 32'd1;
            end
        end
    end

    assign cycle_cnt   = cycle_cnt_q;
    assign instret_cnt = instret_cnt_q;
`else
    assign cycle_cnt   = 32'd0;
    assign instret_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_cpu_mc.sv
// Self-checking bench for cpu_mc: a memory model answers the bus and a scoreboard
// compares every accepted transaction against the program's expected bus trace.
module tb_cpu_mc;
    localparam int ADDR_W = 8;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              mem_req, mem_we, mem_ready, trap, retire;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata, pc_out, cycle_cnt, instret_cnt;
    logic [31:0]       mem_rdata = 32'd0;
    logic [2:0]        dbg_state;

    always #5 clk = ~clk;

    cpu_mc #(.ADDR_W(ADDR_W), .RESET_PC(8'h10), .LR_SEL(15)) dut (
        .clk(clk), .rst(rst),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .trap(trap), .retire(retire), .pc_out(pc_out),
        .cycle_cnt(cycle_cnt), .instret_cnt(instret_cnt), .dbg_state(dbg_state)
    );

    logic [31:0]       mem [256];
    logic [40:0]       exp_q[$];
    logic [40:0]       exp_item;
    logic [ADDR_W-1:0] hold_addr;
    logic [31:0]       hold_pc;
    int n_cmp = 0, n_err = 0;
    int wait_states = 0, wait_cnt = 0, run_cycles = 0, done_cycles = 0, retire_cnt = 0;
    int req_seen = 0, budget = 0;
    bit started = 1'b0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic push(input logic we, input logic [7:0] addr, input logic [31:0] data);
        exp_q.push_back({we, addr, data});
    endtask

    // Memory model: wait states on reads only, scoreboard pop on every accepted request.
    always @(negedge clk) begin
        mem_ready = 1'b0;
        if (rst) begin
            wait_cnt   = 0;
            run_cycles = 0;
            retire_cnt = 0;
            started    = 1'b0;
        end else begin
            if (mem_req) started = 1'b1;
            if (started) run_cycles++;
            if (retire) retire_cnt++;
            if (mem_req) begin
                if (wait_cnt > 0) begin
                    check("hold_addr", 64'(mem_addr), 64'(hold_addr));
                    check("hold_pc", 64'(pc_out), 64'(hold_pc));
                end
                if (!mem_we && (wait_cnt < wait_states)) begin
                    if (wait_cnt == 0) begin
                        hold_addr = mem_addr;
                        hold_pc   = pc_out;
                    end
                    wait_cnt++;
                end else begin
                    mem_ready = 1'b1;
                    wait_cnt  = 0;
                    mem_rdata = mem[mem_addr];
                    if (mem_we) mem[mem_addr] = mem_wdata;
                    if (exp_q.size() != 0) begin
                        exp_item = exp_q.pop_front();
                        check("bus", 64'({mem_we, mem_addr, (mem_we ? mem_wdata : 32'd0)}), 64'(exp_item));
                        if (exp_q.size() == 0) done_cycles = run_cycles;
                    end
                end
            end else if (wait_cnt != 0) begin
                check("req_held", 64'(mem_req), 64'd1);
                wait_cnt = 0;
            end
        end
    end

    task automatic rst_on();
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 check("rst_req_drop", 64'(mem_req), 64'd0);
        @(posedge clk);
        #1;
        check("rst_we", 64'(mem_we), 64'd0);
        check("rst_addr", 64'(mem_addr), 64'd0);
        check("rst_wdata", 64'(mem_wdata), 64'd0);
        check("rst_trap", 64'(trap), 64'd0);
        check("rst_retire", 64'(retire), 64'd0);
        check("rst_pc_out", 64'(pc_out), 64'h40);
        check("rst_cycle_cnt", 64'(cycle_cnt), 64'd0);
        check("rst_instret_cnt", 64'(instret_cnt), 64'd0);
        exp_q.delete();
        for (int i = 0; i < 256; i++) mem[i] = 32'd0;
    endtask

    task automatic wait_done(input int limit);
        budget = 0;
        while ((exp_q.size() != 0) && (budget < limit)) begin
            @(negedge clk);
            #1 budget++;
        end
        check("sb_drain", 64'(exp_q.size()), 64'd0);
        exp_q.delete();
    endtask

    task automatic load_alu_store();
        mem[8'h10] = 32'h0100_0005;
        mem[8'h11] = 32'h2100_0040;
        push(1'b0, 8'h10, 32'd0);
        push(1'b0, 8'h11, 32'd0);
        push(1'b1, 8'h10, 32'd5);
    endtask

    initial begin
        // First fetch after reset, then ALU + store with zero wait states.
        rst_on();
        wait_states = 0;
        load_alu_store();
        rst = 1'b0;
        @(negedge clk);
        #1 check("pre_fetch_req", 64'(mem_req), 64'd0);
        @(negedge clk);
        #1;
        check("first_req", 64'(mem_req), 64'd1);
        check("first_addr", 64'(mem_addr), 64'h10);
        check("first_we", 64'(mem_we), 64'd0);
        check("first_trap", 64'(trap), 64'd0);
        wait_done(50);
        check("cycles_0ws", 64'(done_cycles), 64'd5);
        @(negedge clk);
        #1 check("retires_0ws", 64'(retire_cnt), 64'd2);

        // Same program, three wait states on every read.
        rst_on();
        wait_states = 3;
        load_alu_store();
        rst = 1'b0;
        wait_done(100);
        check("cycles_3ws", 64'(done_cycles), 64'd11);
        @(negedge clk);
        #1 check("retires_3ws", 64'(retire_cnt), 64'd2);

        // Jump to 0x20, branch-and-link -2, store the link register.
        rst_on();
        wait_states = 0;
        mem[8'h10] = 32'h8000_000F;
        mem[8'h20] = 32'h903F_FFFE;
        mem[8'h1F] = 32'h2F00_0200;
        push(1'b0, 8'h10, 32'd0);
        push(1'b0, 8'h20, 32'd0);
        push(1'b0, 8'h1F, 32'd0);
        push(1'b1, 8'h80, 32'h84);
        rst = 1'b0;
        wait_done(50);

        // Conditional branches, indirect jump, load, sub, r0 discard, op=11 ALU, pc wrap.
        rst_on();
        wait_states = $urandom_range(0, 2);
        mem[8'h10] = 32'h80C0_0010;
        mem[8'h11] = 32'h8080_0010;
        mem[8'h22] = 32'h0200_0100;
        mem[8'h23] = 32'hA002_0000;
        mem[8'h40] = 32'h1300_0200;
        mem[8'h41] = 32'h2300_0204;
        mem[8'h42] = 32'h4413_2000;
        mem[8'h43] = 32'h2400_0208;
        mem[8'h44] = 32'h0000_0007;
        mem[8'h45] = 32'h2000_020C;
        mem[8'h46] = 32'h3500_FFF0;
        mem[8'h47] = 32'h2500_0210;
        mem[8'h48] = 32'h8000_00B6;
        mem[8'h80] = 32'hDEAD_BEEF;
        push(1'b0, 8'h10, 32'd0);
        push(1'b0, 8'h11, 32'd0);
        push(1'b0, 8'h22, 32'd0);
        push(1'b0, 8'h23, 32'd0);
        push(1'b0, 8'h40, 32'd0);
        push(1'b0, 8'h80, 32'd0);
        push(1'b0, 8'h41, 32'd0);
        push(1'b1, 8'h81, 32'hDEAD_BEEF);
        push(1'b0, 8'h42, 32'd0);
        push(1'b0, 8'h43, 32'd0);
        push(1'b1, 8'h82, 32'hDEAD_BDEF);
        push(1'b0, 8'h44, 32'd0);
        push(1'b0, 8'h45, 32'd0);
        push(1'b1, 8'h83, 32'd0);
        push(1'b0, 8'h46, 32'd0);
        push(1'b0, 8'h47, 32'd0);
        push(1'b1, 8'h84, 32'hFFFF_FFF0);
        push(1'b0, 8'h48, 32'd0);
        push(1'b0, 8'hFF, 32'd0);
        push(1'b0, 8'h00, 32'd0);
        rst = 1'b0;
        wait_done(300);
        check("retires_mix", 64'(retire_cnt), 64'd14);

        // Undefined instruction: sticky trap, bus silent, cleared only by reset.
        rst_on();
        wait_states = 0;
        mem[8'h10] = 32'hC000_0000;
        push(1'b0, 8'h10, 32'd0);
        rst = 1'b0;
        wait_done(20);
        @(negedge clk);
        #1 check("trap_in_exec", 64'(trap), 64'd0);
        @(negedge clk);
        #1;
        check("trap_set", 64'(trap), 64'd1);
        check("trap_state", 64'(dbg_state), 64'd5);
        req_seen = 0;
        repeat (20) begin
            @(negedge clk);
            #1 if (mem_req) req_seen++;
        end
        check("trap_no_req", 64'(req_seen), 64'd0);
        check("trap_no_retire", 64'(retire_cnt), 64'd0);
        check("trap_pc_frozen", 64'(pc_out), 64'h44);
        check("trap_sticky", 64'(trap), 64'd1);
        rst_on();
        push(1'b0, 8'h10, 32'd0);
        rst = 1'b0;
        wait_done(20);
        check("trap_cleared", 64'(trap), 64'd0);

        // Ten back-to-back ALU instructions for the performance counters.
        rst_on();
        wait_states = 0;
        for (int i = 0; i < 16; i++) mem[8'h10 + i] = 32'h0101_0001;
        rst = 1'b0;
        budget = 0;
        while ((retire_cnt < 10) && (budget < 100)) begin
            @(negedge clk);
            #1 budget++;
        end
        check("perf_retires", 64'(retire_cnt), 64'd10);
`ifdef CPU_MC_PERF_EN
        check("perf_instret", 64'(instret_cnt), 64'd10);
        check("perf_cycles", 64'(cycle_cnt), 64'd20);
`else
        check("perf_instret_off", 64'(instret_cnt), 64'd0);
        check("perf_cycles_off", 64'(cycle_cnt), 64'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
